// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse train generator.
// Each channel runs IDLE -> HIGH -> (GAP -> HIGH)* -> IDLE from a latched,
// clamped width/gap/count configuration loaded over a valid/ready command port.
module pulse_train_gen #(
    parameter int unsigned NUM_CH  = 32,
    parameter int unsigned CNT_W   = 22,
    parameter int unsigned MIN_CYC = 4,
    parameter int unsigned MAX_CYC = 4_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_ch,
    input  logic [CNT_W-1:0]  cmd_width,
    input  logic [CNT_W-1:0]  cmd_gap,
    input  logic [7:0]        cmd_count,
    input  logic [NUM_CH-1:0] abort,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [CNT_W-1:0] wid_q   [NUM_CH];
    logic [CNT_W-1:0] wid_d   [NUM_CH];
    logic [CNT_W-1:0] gap_q   [NUM_CH];
    logic [CNT_W-1:0] gap_d   [NUM_CH];
    // Remaining pulses; 0 while running means continuous mode.
    logic [7:0]       rem_q   [NUM_CH];
    logic [7:0]       rem_d   [NUM_CH];

    logic [NUM_CH-1:0] pulse_d;
    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] done_d;
    logic              accept;
    logic [CNT_W-1:0]  width_cl;
    logic [CNT_W-1:0]  gap_cl;

    // Limit a requested length to the supported pulse/gap range.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
        if (v < CNT_W'(MIN_CYC)) begin
            return CNT_W'(MIN_CYC);
        end else if (v > CNT_W'(MAX_CYC)) begin
            return CNT_W'(MAX_CYC);
        end
        return v;
    endfunction

    // Ready only for an idle, non-aborted target channel.
    assign cmd_ready = (state_q[cmd_ch] == IDLE) && !abort[cmd_ch];
    assign accept    = cmd_valid && cmd_ready;
    assign width_cl  = clamp_len(cmd_width);
    assign gap_cl    = clamp_len(cmd_gap);

    // Per-channel next state, counters and next registered outputs.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            wid_d[i]   = wid_q[i];
            gap_d[i]   = gap_q[i];
            rem_d[i]   = rem_q[i];
            pulse_d[i] = 1'b0;
            busy_d[i]  = 1'b0;
            done_d[i]  = 1'b0;

            if (abort[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                rem_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (accept && (cmd_ch == 5'(i))) begin
                            state_d[i] = HIGH;
                            cnt_d[i]   = '0;
                            wid_d[i]   = width_cl;
                            gap_d[i]   = gap_cl;
                            rem_d[i]   = cmd_count;
                        end
                    end
                    HIGH: begin
                        if (cnt_q[i] == wid_q[i] - CNT_W'(1)) begin
                            cnt_d[i] = '0;
                            if (rem_q[i] == 8'd0) begin
                                state_d[i] = GAP;
                            end else if (rem_q[i] == 8'd1) begin
                                rem_d[i]   = 8'd0;
                                state_d[i] = IDLE;
                            end else begin
                                rem_d[i]   = rem_q[i] - 8'd1;
                                state_d[i] = GAP;
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    GAP: begin
                        if (cnt_q[i] == gap_q[i] - CNT_W'(1)) begin
                            cnt_d[i]   = '0;
                            state_d[i] = HIGH;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        rem_d[i]   = '0;
                    end
                endcase
            end

            pulse_d[i] = (state_d[i] == HIGH);
            busy_d[i]  = (state_d[i] != IDLE);
            // Strobe during the final high cycle of the last pulse of a finite train.
            done_d[i]  = (state_d[i] == HIGH) &&
                         (cnt_d[i] == wid_d[i] - CNT_W'(1)) &&
                         (rem_d[i] == 8'd1);
        end
    end

    // State, configuration and registered output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                wid_q[i]   <= '0;
                gap_q[i]   <= '0;
                rem_q[i]   <= '0;
            end
            pulse_out <= '0;
            busy      <= '0;
            done      <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                wid_q[i]   <= wid_d[i];
                gap_q[i]   <= gap_d[i];
                rem_q[i]   <= rem_d[i];
            end
            pulse_out <= pulse_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen.
module tb_pulse_train_gen;

    localparam int unsigned NUM_CH = 32;
    localparam int unsigned CNT_W  = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_ch;
    logic [CNT_W-1:0]  cmd_width;
    logic [CNT_W-1:0]  cmd_gap;
    logic [7:0]        cmd_count;
    logic [NUM_CH-1:0] abort;
    logic [NUM_CH-1:0] pulse_out;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    int n_assert = 0;
    int n_fail   = 0;

    pulse_train_gen dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_width (cmd_width),
        .cmd_gap   (cmd_gap),
        .cmd_count (cmd_count),
        .abort     (abort),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    // 20 MHz clock
    always #25 clk = ~clk;

    // Present one command for one cycle; returns at the negedge after the accept edge.
    task automatic issue_cmd(input int ch, input int w, input int g, input int c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ch    = 5'(ch);
        cmd_width = CNT_W'(w);
        cmd_gap   = CNT_W'(g);
        cmd_count = 8'(c);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_width = '0;
        cmd_gap   = '0;
        cmd_count = '0;
        abort     = '0;
        #60;
        n_assert++;
        if ({pulse_out, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {pulse_out, busy, done});
        end
        n_assert++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [15:0] p, b, d;
        issue_cmd(0, 4, 4, 1);
        for (int k = 0; k < 16; k++) begin
            p[k] = pulse_out[0];
            b[k] = busy[0];
            d[k] = done[0];
            @(negedge clk);
        end
        n_assert++;
        if (p !== 16'h000F) begin
            n_fail++;
            $display("FAIL single_pulse: got %h expected %h", p, 16'h000F);
        end
        n_assert++;
        if (b !== 16'h000F) begin
            n_fail++;
            $display("FAIL single_busy: got %h expected %h", b, 16'h000F);
        end
        n_assert++;
        if (d !== 16'h0008) begin
            n_fail++;
            $display("FAIL single_done: got %h expected %h", d, 16'h0008);
        end
    endtask

    task automatic test_train();
        logic [63:0] p, b, d, ep, eb, ed;
        issue_cmd(5, 10, 6, 3);
        for (int k = 0; k < 64; k++) begin
            ep[k] = (k < 48) && ((k % 16) < 10);
            eb[k] = (k < 42);
            ed[k] = (k == 41);
            p[k]  = pulse_out[5];
            b[k]  = busy[5];
            d[k]  = done[5];
            @(negedge clk);
        end
        n_assert++;
        if (p !== ep) begin
            n_fail++;
            $display("FAIL train_pulse: got %h expected %h", p, ep);
        end
        n_assert++;
        if (b !== eb) begin
            n_fail++;
            $display("FAIL train_busy: got %h expected %h", b, eb);
        end
        n_assert++;
        if (d !== ed) begin
            n_fail++;
            $display("FAIL train_done: got %h expected %h", d, ed);
        end
    endtask

    task automatic test_clamp();
        logic [7:0]  p8;
        logic [15:0] p, b, d;
        int          hi;
        int          bl;
        hi = 0;
        bl = 0;
        // Width 1 -> 4; gap at counter maximum -> 4_000_000, far longer than the window.
        issue_cmd(1, 1, 22'h3FFFFF, 2);
        for (int k = 0; k < 2000; k++) begin
            if (k < 8) p8[k] = pulse_out[1];
            if (pulse_out[1]) hi++;
            if (!busy[1]) bl++;
            @(negedge clk);
        end
        n_assert++;
        if (p8 !== 8'h0F) begin
            n_fail++;
            $display("FAIL clamp_width_low: got %h expected %h", p8, 8'h0F);
        end
        n_assert++;
        if (hi != 4) begin
            n_fail++;
            $display("FAIL clamp_gap_high_hi: got %0d expected 4", hi);
        end
        n_assert++;
        if (bl != 0) begin
            n_fail++;
            $display("FAIL clamp_gap_high_busy: got %0d idle cycles expected 0", bl);
        end
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        n_assert++;
        if (busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_abort_busy: got %b expected 0", busy[1]);
        end
        // Width 0 and gap 1 both clamp to 4.
        issue_cmd(3, 0, 1, 2);
        for (int k = 0; k < 16; k++) begin
            p[k] = pulse_out[3];
            b[k] = busy[3];
            d[k] = done[3];
            @(negedge clk);
        end
        n_assert++;
        if ({p, b, d} !== {16'h0F0F, 16'h0FFF, 16'h0800}) begin
            n_fail++;
            $display("FAIL clamp_low_pattern: got %h/%h/%h expected 0f0f/0fff/0800", p, b, d);
        end
    endtask

    task automatic test_abort();
        logic [17:0] p, ep;
        int          dn;
        dn = 0;
        issue_cmd(31, 4, 4, 0);
        for (int k = 0; k < 18; k++) begin
            ep[k] = ((k % 8) < 4);
            p[k]  = pulse_out[31];
            if (done[31]) dn++;
            @(negedge clk);
        end
        n_assert++;
        if (p !== ep) begin
            n_fail++;
            $display("FAIL abort_continuous: got %h expected %h", p, ep);
        end
        n_assert++;
        if (pulse_out[31] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_prehigh: got %b expected 1", pulse_out[31]);
        end
        abort[31] = 1'b1;
        cmd_ch    = 5'd31;
        #1;
        n_assert++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready_low: got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        n_assert++;
        if ({pulse_out[31], busy[31]} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_stop: got %b expected 00", {pulse_out[31], busy[31]});
        end
        for (int k = 0; k < 4; k++) begin
            if (done[31] || busy[31]) dn++;
            @(negedge clk);
        end
        abort[31] = 1'b0;
        #1;
        n_assert++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready_back: got %b expected 1", cmd_ready);
        end
        n_assert++;
        if (dn != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d strobes expected 0", dn);
        end
    endtask

    task automatic test_reject();
        int hi;
        int dn;
        hi = 0;
        dn = 0;
        issue_cmd(2, 20, 4, 1);
        cmd_valid = 1'b1;
        cmd_ch    = 5'd2;
        cmd_width = CNT_W'(4);
        cmd_count = 8'd5;
        #1;
        n_assert++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ready: got %b expected 0", cmd_ready);
        end
        for (int k = 0; k < 30; k++) begin
            if (pulse_out[2]) hi++;
            if (done[2]) dn++;
            if (k == 5) cmd_valid = 1'b0;
            @(negedge clk);
        end
        n_assert++;
        if ({hi, dn} !== {32'd20, 32'd1}) begin
            n_fail++;
            $display("FAIL busy_ignored: got hi=%0d done=%0d expected hi=20 done=1", hi, dn);
        end
        n_assert++;
        if (busy[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end: got %b expected 0", busy[2]);
        end
        abort[7]  = 1'b1;
        cmd_valid = 1'b1;
        cmd_ch    = 5'd7;
        cmd_count = 8'd1;
        #1;
        n_assert++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_accept_ready: got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        abort[7]  = 1'b0;
        @(negedge clk);
        n_assert++;
        if ({pulse_out[7], busy[7]} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_accept_taken: got %b expected 00", {pulse_out[7], busy[7]});
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        for (int ch = 0; ch < 32; ch++) begin
            issue_cmd(ch, 100, 4, 0);
        end
        n_assert++;
        if ({pulse_out, busy} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
            n_fail++;
            $display("FAIL rst_all_running: got %h/%h expected all ones", pulse_out, busy);
        end
        #5;
        rst = 1'b1;
        #1;
        n_assert++;
        if ({pulse_out, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_clear: got %h expected 0", {pulse_out, busy, done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ({pulse_out, busy, done} !== '0) bad++;
        end
        n_assert++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_stays_idle: got %0d active cycles expected 0", bad);
        end
        issue_cmd(0, 4, 4, 1);
        n_assert++;
        if ({pulse_out[0], busy[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_new_cmd: got %b expected 11", {pulse_out[0], busy[0]});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_train();
        test_clamp();
        test_abort();
        test_reject();
        test_reset_mid();
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
